// File: rtl/gray_to_binary_tracker.sv
// Two-stage Gray-to-binary decoder that tracks step direction and flags
// non-adjacent consecutive samples, with a saturating error counter.
//
// state | meaning
// EMPTY | no previous sample since reset; next sample only seeds prev
// TRACK | prev holds the last decoded value; each sample is checked against it
module gray_to_binary_tracker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin_out,
    output logic             dir_up,
    output logic             step_err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] STEP_UP = WIDTH'(1);
    localparam logic [WIDTH-1:0] STEP_DN = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic             v1;
    logic [WIDTH-1:0] g1;
    logic [WIDTH-1:0] bin_dec;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_nxt;
    logic [WIDTH-1:0] delta;
    logic             dir_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            g1 <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                g1 <= gray_in;
            end
        end
    end

    // Prefix XOR from the MSB down.
    always_comb begin
        bin_dec = '0;
        bin_dec[WIDTH-1] = g1[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin_dec[i] = bin_dec[i+1] ^ g1[i];
        end
    end

    // Modular difference makes max->0 and 0->max legal single steps.
    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        dir_nxt   = dir_up;
        err_nxt   = 1'b0;
        cnt_nxt   = err_cnt;
        delta     = bin_dec - prev;
        if (v1) begin
            prev_nxt  = bin_dec;
            state_nxt = TRACK;
            if (state == TRACK) begin
                if (delta == STEP_UP) begin
                    dir_nxt = 1'b1;
                end else if (delta == STEP_DN) begin
                    dir_nxt = 1'b0;
                end else if (delta != '0) begin
                    err_nxt = 1'b1;
                    if (err_cnt != CNT_MAX) begin
                        cnt_nxt = err_cnt + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            prev      <= '0;
            out_valid <= 1'b0;
            bin_out   <= '0;
            dir_up    <= 1'b1;
            step_err  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            out_valid <= v1;
            if (v1) begin
                bin_out <= bin_dec;
            end
            dir_up    <= dir_nxt;
            step_err  <= err_nxt;
            err_cnt   <= cnt_nxt;
        end
    end

endmodule

// File: doc/gray_to_binary_tracker.md
Name: gray_to_binary_tracker

Overview:
- Registered Gray-to-binary decoder: the receive end of the 4-bit Gray encoding produced by binary_to_gray.
- Accepts a stream of Gray-coded samples, such as position or pointer codes.
- Emits the binary value, the direction of travel, and a step-error flag when consecutive samples are not adjacent codes.
- Keeps a saturating error count for the link.

Parameters:
WIDTH, 4, code width in bits (>=2)
CNT_W, 8, width of error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  gray_in is valid this cycle
gray_in  input  WIDTH  Gray-coded sample
out_valid  output  1  one-cycle pulse, bin_out/dir_up/step_err valid
bin_out  output  WIDTH  decoded binary value
dir_up  output  1  last legal step direction: 1=up, 0=down
step_err  output  1  decoded sample not within +/-1 of previous sample
err_cnt  output  CNT_W  saturating count of step_err events

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst. No asynchronous paths.
- Reset values: out_valid=0, bin_out=0, dir_up=1, step_err=0, err_cnt=0. Stage-1 registers, prev value and state are also cleared; state=EMPTY.
- Always ready; no backpressure. Every cycle with in_valid=1 accepts one sample.
- Pipeline, 2 register stages:
  - Edge E (in_valid=1): stage 1 captures gray_in and v1=1.
  - Edge E+1: stage 2 registers the results, so outputs are valid in the cycle after E+1.
  - Latency is 2 edges; throughput is 1 sample/cycle.
- Decode: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1] XOR g[i] for i down to 0. This is pure prefix XOR, computed between the stages.
- out_valid is 1 for exactly one cycle per accepted sample. Back-to-back samples give consecutive out_valid pulses.
- bin_out, dir_up and err_cnt hold their values while out_valid=0. step_err is 0 whenever out_valid=0.
- State machine (updated at edge E+1 of each sample):
  - EMPTY: no previous sample. First sample gives step_err=0 and leaves dir_up unchanged. Store prev=b, go to TRACK.
  - TRACK: let d = (b - prev) mod 2^WIDTH.
    - d=0: repeat; step_err=0, dir_up unchanged.
    - d=1: step_err=0, dir_up=1.
    - d=2^WIDTH-1: step_err=0, dir_up=0.
    - Any other d: step_err=1, dir_up unchanged; err_cnt += 1, saturating at 2^CNT_W-1.
    - In all cases prev=b and the state stays TRACK.
- Wrap-around: max->0 is a legal up step and 0->max is a legal down step (modular arithmetic).
- Hamming distance alone is NOT the legality test. Example: gray 0000->0010 is distance 1 but binary 0->3, so it is a step_err.
- Reset mid-operation: samples in flight are discarded. No out_valid is produced for a sample captured before or at the reset edge. The state returns to EMPTY, so the first sample after reset never flags step_err.
- in_valid while rst=1 is ignored.
- err_cnt does not wrap; it stays saturated until reset.

Test Plan:
1. Reset, then one sample each, spaced apart: gray 0011, 1011, 1111 -> bin_out 0010, 1101, 1010. Each has out_valid for 1 cycle, 2 edges after capture. First sample step_err=0.
2. Back-to-back gray 0000,0001,0011,0010,0110 -> bin 0,1,2,3,4 on 5 consecutive out_valid cycles; dir_up=1, step_err=0, err_cnt=0.
3. Wrap and reverse: gray 1000 (bin 15) -> 0000 (bin 0): dir_up=1, no error. Then 0000 -> 1000: dir_up=0, no error. Then repeat 1000: step_err=0, dir_up stays 0.
4. Illegal jumps:
   - 0000 -> 0010 (0->3): step_err=1, err_cnt=1, dir_up unchanged.
   - Then 0110 (bin 4, +1 from 3): step_err=0.
   - With CNT_W=2, five alternating 0000/1100 (bin 0/8) samples: err_cnt saturates at 3.
5. Reset mid-stream: assert rst for 1 cycle in the edge after capturing a sample.
   - Required: no out_valid for that sample; all outputs at reset values.
   - Next sample 1111 gives bin 1010 with step_err=0 (EMPTY state).
6. in_valid gaps: toggle in_valid 1,0,1 with gray 0001, X, 0011. The X value is ignored. Required: two out_valid pulses, bin 1 then 2, no error, and outputs hold between pulses.
